// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative RV32M multiply/divide unit (shift-add / restoring).
//            Optional zero/div-by-zero/overflow bypass: MULDIV_FASTPATH_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             kill_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_src1;
  logic [WIDTH-1:0]   r_result;
  logic [CW-1:0]      r_cnt;
  logic [2:0]         r_op;
  logic               r_sign_q, r_sign_r, r_div_zero, r_div_ovf;

  // Operand decode at acceptance
  logic             w_accept, w_fast, w_last;
  logic             w_a_signed, w_b_signed, w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic             w_div_zero, w_div_ovf;

  assign w_accept   = start_i && (r_state != S_CALC);
  assign w_a_signed = ~op_i[2] ? (op_i[1:0] != 2'b11) : ~op_i[0];
  assign w_b_signed = ~op_i[2] ? ~op_i[1] : ~op_i[0];
  assign w_a_neg    = w_a_signed & src1_i[WIDTH-1];
  assign w_b_neg    = w_b_signed & src2_i[WIDTH-1];
  assign w_a_mag    = w_a_neg ? (~src1_i + 1'b1) : src1_i;
  assign w_b_mag    = w_b_neg ? (~src2_i + 1'b1) : src2_i;
  assign w_div_zero = op_i[2] & (src2_i == '0);
  assign w_div_ovf  = op_i[2] & ~op_i[0] & (src1_i == MIN_NEG) & (src2_i == '1);
  assign w_last     = (r_cnt == CW'(WIDTH));

`ifdef MULDIV_FASTPATH_EN
  logic [WIDTH-1:0] w_fast_res;
  assign w_fast = w_div_zero | w_div_ovf |
                  (~op_i[2] & ((src1_i == '0) | (src2_i == '0)));
  always_comb begin
    w_fast_res = '0;
    if (w_div_zero)
      w_fast_res = op_i[1] ? src1_i : '1;
    else if (w_div_ovf)
      w_fast_res = op_i[1] ? '0 : MIN_NEG;
  end
`else
  assign w_fast = 1'b0;
`endif

  // One iteration of the shared datapath; low half holds multiplier/dividend
  logic [WIDTH:0]     w_sum, w_diff;
  logic [2*WIDTH:0]   w_shifted;
  logic [2*WIDTH-1:0] w_step;

  assign w_sum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_shifted = {r_acc, 1'b0};
  assign w_diff    = w_shifted[2*WIDTH:WIDTH] - {1'b0, r_b};
  assign w_step    = ~r_op[2] ? {w_sum, r_acc[WIDTH-1:1]}
                   : (w_diff[WIDTH] ? w_shifted[2*WIDTH-1:0]
                                    : {w_diff[WIDTH-1:0], w_shifted[WIDTH-1:1], 1'b1});

  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quot, w_rem, w_final;

  assign w_prod_s = r_sign_q ? (~r_acc + 1'b1) : r_acc;
  assign w_quot   = r_acc[WIDTH-1:0];
  assign w_rem    = r_acc[2*WIDTH-1:WIDTH];

  always_comb begin
    w_final = '0;
    if (~r_op[2])
      w_final = (r_op[1:0] == 2'b00) ? w_prod_s[WIDTH-1:0] : w_prod_s[2*WIDTH-1:WIDTH];
    else if (~r_op[1])
      w_final = r_div_zero ? '1 : r_div_ovf ? MIN_NEG :
                (r_sign_q ? (~w_quot + 1'b1) : w_quot);
    else
      w_final = r_div_zero ? r_src1 : r_div_ovf ? '0 :
                (r_sign_r ? (~w_rem + 1'b1) : w_rem);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept)               w_next = w_fast ? S_DONE : S_CALC;
        else if (r_state == S_DONE) w_next = S_IDLE;
      end
      S_CALC: begin
        if (kill_i)      w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc      <= '0;
      r_b        <= '0;
      r_src1     <= '0;
      r_result   <= '0;
      r_cnt      <= '0;
      r_op       <= '0;
      r_sign_q   <= 1'b0;
      r_sign_r   <= 1'b0;
      r_div_zero <= 1'b0;
      r_div_ovf  <= 1'b0;
    end else if (w_accept) begin
      r_acc      <= {{WIDTH{1'b0}}, w_a_mag};
      r_b        <= w_b_mag;
      r_src1     <= src1_i;
      r_cnt      <= '0;
      r_op       <= op_i;
      r_sign_q   <= w_a_neg ^ w_b_neg;
      r_sign_r   <= w_a_neg;
      r_div_zero <= w_div_zero;
      r_div_ovf  <= w_div_ovf;
`ifdef MULDIV_FASTPATH_EN
      if (w_fast) r_result <= w_fast_res;
`endif
    end else if (r_state == S_CALC && !kill_i) begin
      // The cycle after the last iteration applies sign fix-up and special cases
      if (!w_last) begin
        r_acc <= w_step;
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_result <= w_final;
      end
    end
  end

  assign busy_o   = (r_state == S_CALC);
  assign done_o   = (r_state == S_DONE);
  assign result_o = r_result;

endmodule

`default_nettype wire

// File: tb/tb_muldiv_unit.sv
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Directed self-checking bench for muldiv_unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_muldiv_unit;

  localparam int WIDTH = 32;
  localparam int LAT   = WIDTH + 1;
`ifdef MULDIV_FASTPATH_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  logic              clk = 1'b0, rst = 1'b1, start = 1'b0, kill = 1'b0;
  logic [2:0]        op = '0;
  logic [WIDTH-1:0]  a = '0, b = '0;
  logic              busy, done;
  logic [WIDTH-1:0]  result;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start),
    .op_i    (op),
    .src1_i  (a),
    .src2_i  (b),
    .kill_i  (kill),
    .busy_o  (busy),
    .done_o  (done),
    .result_o(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit busy_ok);
    cyc = 0;
    busy_ok = 1'b1;
    while (!done && cyc < 200) begin
      if (!busy) busy_ok = 1'b0;
      tick();
      cyc++;
    end
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp, input bit special, input string tag);
    int cyc;
    bit bok;
    launch(o, x, y);
    wait_done(cyc, bok);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " latency"}, cyc, (FAST && special) ? 0 : LAT);
    check({tag, " result"}, result, exp);
    check({tag, " busy during calc"}, 32'(bok), 32'd1);
    check({tag, " busy at done"}, 32'(busy), 32'd0);
    tick();
    check({tag, " done pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cyc;
    bit bok;
    bit seen;

    // Reset state
    repeat (3) tick();
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset result", result, 32'd0);
    rst = 1'b0;

    // Multiply
    run(MUL,    32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1'b0, "mul");
    run(MULH,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0, "mulh");
    run(MULHU,  32'hFFFFFFFF, 32'h00000002, 32'h00000001, 1'b0, "mulhu");
    run(MULHSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 1'b0, "mulhsu");
    run(MUL,    32'h00001234, 32'h00010000, 32'h12340000, 1'b0, "mul shift");

    // Reset in the middle of an operation
    launch(MUL, 32'd7, 32'd6);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    check("midreset busy", 32'(busy), 32'd0);
    check("midreset done", 32'(done), 32'd0);
    check("midreset result", result, 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("midreset no done", 32'(seen), 32'd0);

    run(MUL, 32'd0, 32'd5, 32'd0, 1'b1, "mul zero");

    // Divide
    run(DIV,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1'b0, "div -7/2");
    run(REM,  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1'b0, "rem -7/2");
    run(DIVU, 32'd100, 32'd7, 32'd14, 1'b0, "divu 100/7");
    run(DIV,  32'd5, 32'd0, 32'hFFFFFFFF, 1'b1, "div by zero");
    run(REMU, 32'd5, 32'd0, 32'd5, 1'b1, "remu by zero");
    run(REM,  32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1'b1, "rem -5/0");
    run(DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, "div ovf");
    run(REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b1, "rem ovf");
    run(REMU, 32'd100, 32'd7, 32'd2, 1'b0, "remu 100/7");

    // Kill during CALC
    launch(DIVU, 32'd100, 32'd7);
    repeat (4) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    check("kill busy", 32'(busy), 32'd0);
    check("kill done", 32'(done), 32'd0);
    check("kill result held", result, 32'd2);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("kill no done", 32'(seen), 32'd0);

    // Start while busy is ignored
    launch(DIVU, 32'd100, 32'd7);
    repeat (3) tick();
    op = MUL; a = 32'd3; b = 32'd4; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc, bok);
    check("busy start latency", cyc + 4, LAT);
    check("busy start result", result, 32'd14);
    tick();

    // Back-to-back via start in DONE
    launch(MUL, 32'd3, 32'd4);
    wait_done(cyc, bok);
    check("b2b first latency", cyc, LAT);
    check("b2b first result", result, 32'd12);
    op = DIVU; a = 32'd9; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("b2b busy", 32'(busy), 32'd1);
    wait_done(cyc, bok);
    check("b2b second latency", cyc, LAT);
    check("b2b second result", result, 32'd3);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle RV32M multiply/divide unit in the EX stage.
- Its result_o feeds the src1_i leg of the 32-bit writeback-select mux, with ALU result on src0_i and select driven by done_o.
- Iterative shift-add multiplier and restoring divider share one 2*WIDTH datapath, sequenced by a small FSM.
- Hazard unit stalls the pipeline on busy_o.

Parameters:
- WIDTH, 32, operand/result width; only 32 is verified.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, synchronous, active-high
- start_i  input  1  request; accepted only when busy_o=0
- op_i  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- src1_i  input  WIDTH  rs1 operand
- src2_i  input  WIDTH  rs2 operand
- kill_i  input  1  flush; aborts an in-flight operation
- busy_o  output  1  operation in progress
- done_o  output  1  one-cycle pulse, result_o valid
- result_o  output  WIDTH  result; held until next accepted start

Behaviour:
- Reset: on rising clk with rst_i=1, state=IDLE, busy_o=0, done_o=0, result_o=0, counter=0. rst_i overrides every other input.
- States: IDLE, CALC, DONE.
- IDLE or DONE, start_i=1:
  - latch op_i.
  - latch magnitudes of src1_i/src2_i and result signs.
  - counter=0, go to CALC.
  - busy_o=1 from the next cycle.
- CALC: one iteration per cycle, counter 0..WIDTH-1. After iteration WIDTH-1, go to DONE.
- DONE: exactly one cycle. done_o=1, busy_o=0, result_o updated in the same edge.
  - start_i=1 in DONE is accepted (back-to-back, next state CALC).
  - otherwise the next state is IDLE.
- Latency: start sampled at edge N; done_o high during the cycle after edge N+WIDTH+1 (34 cycles total for WIDTH=32).
- start_i while busy_o=1: ignored, no effect on the operation.
- kill_i=1 in CALC: next state IDLE, no done_o, result_o unchanged. kill_i in IDLE/DONE has no effect; kill_i has priority over start_i in the same cycle.
- Multiply:
  - unsigned 2*WIDTH product of magnitudes, then negated if signs differ.
  - MUL returns product[WIDTH-1:0]; MULH/MULHSU/MULHU return product[2W-1:W].
  - MULHSU treats src1 signed, src2 unsigned; MULHU treats both unsigned.
- Divide: restoring division on magnitudes. Quotient negated if signs differ (DIV). Remainder takes dividend's sign (REM).
- Divide by zero: DIV/DIVU quotient = all ones; REM/REMU remainder = src1_i.
- Signed overflow (src1=0x80000000, src2=0xFFFFFFFF): DIV = 0x80000000, REM = 0.
- Special-case results are selected at DONE from latched flags; the iteration count is unchanged unless the optional feature is enabled.

Optional Feature:
- Macro MULDIV_FASTPATH_EN.
- Defined:
  - divide-by-zero, signed-overflow divide, and any multiply with a zero operand skip CALC: IDLE/DONE -> DONE directly.
  - done_o is high the cycle after acceptance (latency 1); busy_o is never asserted for these ops.
- Undefined: every op takes the full WIDTH-iteration latency; results are identical.

Test Plan:
- Reset mid-operation: start MUL 7*6, assert rst_i at cycle 10 -> next cycle busy_o=0, done_o=0, result_o=0; no done_o pulse follows.
- MUL 0xFFFFFFFF*0x00000002 -> result_o=0xFFFFFFFE. MULH same operands -> 0xFFFFFFFF. MULHU same operands -> 0x00000001. done_o exactly 34 cycles after start, busy_o high cycles 1..33.
- DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Divide by zero: DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. Overflow: DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0. With MULDIV_FASTPATH_EN, done_o one cycle after start.
- kill_i asserted at CALC cycle 5 of DIVU 100/7 -> no done_o, result_o keeps previous value, busy_o=0 next cycle. A start_i during busy_o=1 is ignored.
- Back-to-back: start MUL 3*4, hold start_i=1 with DIVU 9/3 in the DONE cycle -> done_o with 12, then 34 cycles later done_o with 3.
